etapa_fetch: RTL and testbench
==============================

# etapa_fetch

Instruction-fetch stage and IF/ID pipeline register of the RISC-V core. It holds the fetch PC, issues one word read at a time to instruction memory over a request/ack/response handshake, and registers each returned instruction with its PC for the decode stage. Decode logic, including the immediate generator, reads `instruccion_id`. The block absorbs decode stalls with a one-entry skid buffer. It also honours branch and jump redirects from EX, discarding any fetch already in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP`, default 32'h0000_0013: value of `instruccion_id` after reset and flush (`addi x0,x0,0`).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request valid; held with `imem_addr` stable until `imem_ack`.
- `imem_addr` out 32: word address of the request; bits [1:0] always 0.
- `imem_ack` in 1: request accepted this cycle; a request is accepted only while `imem_req`=1.
- `imem_rvalid` in 1: response valid, at least 1 cycle after the ack; exactly one per ack, in order.
- `imem_rdata` in 32: instruction word, qualified by `imem_rvalid`.
- `stall_id` in 1: decode cannot consume the current IF/ID contents.
- `redirect` in 1: taken branch or jump from EX.
- `redirect_pc` in 32: target address; bits [1:0] ignored.
- `instruccion_id` out 32: registered instruction to decode.
- `pc_id` out 32: PC of `instruccion_id`.
- `valid_id` out 1: IF/ID holds a live instruction.

## Operation
- The FSM has three states:
  - REQ: `imem_req`=1, `imem_addr`=`fetch_pc`.
  - WAIT: a request is outstanding.
  - FULL: the skid buffer is occupied; `imem_req`=0.
- At most one request is outstanding. `imem_req` is asserted only in REQ, and is 0 in any cycle where `rst`=1.
- REQ → WAIT on `imem_ack`: `inflight_pc`←`fetch_pc`, `fetch_pc`←`fetch_pc`+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0).
- In WAIT, on `imem_rvalid` with `kill`=0:
  - IF/ID accepts the response when `valid_id`=0 or `stall_id`=0. It loads `instruccion_id`←`imem_rdata`, `pc_id`←`inflight_pc`, `valid_id`←1. Next state is REQ.
  - Otherwise the response goes into the skid buffer (data and PC). Next state is FULL.
- In WAIT, on `imem_rvalid` with `kill`=1: the response is discarded, `kill`←0, next state is REQ.
- FULL with `stall_id`=0: the skid entry moves into IF/ID, `valid_id`=1, next state is REQ.
- IF/ID hold and drain:
  - `stall_id`=1: IF/ID holds its contents.
  - `stall_id`=0 and no new entry loading that cycle: `valid_id`←0; `instruccion_id` and `pc_id` hold.
- Redirect has the highest priority, overriding `stall_id`:
  - Every redirect sets `fetch_pc`←{`redirect_pc`[31:2],2'b00}, `valid_id`←0, `instruccion_id`←`NOP`, and empties the skid buffer.
  - From REQ without ack: next state REQ; the new address appears on `imem_addr` the next cycle (an unacked request may change address).
  - From REQ with `imem_ack` in the same cycle, or from WAIT without `imem_rvalid`: next state WAIT, `kill`←1.
  - From WAIT with `imem_rvalid` in the same cycle: the response is discarded, next state REQ.
  - From FULL: next state REQ.
- Reset values:
  - State REQ, `fetch_pc`=`RESET_PC`, `kill`=0, skid empty.
  - `valid_id`=0, `instruccion_id`=`NOP`, `pc_id`=0, `imem_req`=0.
  - Reset mid-transaction drops the outstanding response; the memory is reset by the same `rst`.

## Timing
- First `imem_req` appears in the first cycle after `rst` deasserts.
- `valid_id` rises on the clock edge that samples `imem_rvalid`, so it is visible the cycle after the response.
- Best-case throughput is one instruction per 2 cycles: ack in the request cycle, rvalid the next cycle.
- Redirect to a new `imem_req` address takes 1 cycle when no request is outstanding. Otherwise it waits for the killed response.
- In FULL, the skid entry moves to IF/ID the cycle after `stall_id` falls; a new request follows in the same cycle as that move.

## Test plan
- Reset, then memory that acks immediately and returns `rvalid` 1 cycle later. Required: `imem_addr` sequence 0,4,8,C; `pc_id` sequence 0,4,8; `valid_id` pulsing every 2 cycles; `instruccion_id`=`NOP` until the first response.
- Hold `stall_id`=1 across two responses. Required: IF/ID holds the PC=0 instruction; the second response (PC=4) goes to the skid; `imem_req`=0. On release, `pc_id`=4 one cycle later and the next request is to addr 8.
- Redirect to 32'h0000_0103 while WAIT for addr 8 is pending. Required: `valid_id`→0; the addr-8 response is discarded; the next request is to 32'h0000_0100; `pc_id`=100.
- Redirect in the same cycle as `imem_ack`. Required: that response is killed and the next `imem_addr` equals the redirect target.
- `RESET_PC`=32'hFFFF_FFFC. Required: the second fetch is to addr 0 (wrap).
- Assert `rst` while WAIT, with `stall_id`=1 and the skid full. Required: all outputs return to reset values and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/etapa_fetch.sv
`timescale 1ns/1ps
// etapa_fetch: instruction-fetch stage plus IF/ID pipeline register.
// Keeps the fetch PC and issues one word read at a time over a req/ack/rvalid
// handshake. It registers each returned word with its PC for decode. A one-entry
// skid buffer absorbs decode stalls. EX redirects discard any in-flight fetch.
module etapa_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_id,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruccion_id,
  output logic [31:0] pc_id,
  output logic        valid_id
);

  // REQ: request on the bus; WAIT: one request outstanding; FULL: skid occupied
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  state_t      r_state, w_state_next;
  logic [31:0] r_fetch_pc, w_fetch_pc_next;
  logic [31:0] r_inflight_pc, w_inflight_pc_next;
  logic        r_kill, w_kill_next;
  logic [31:0] r_skid_instr, w_skid_instr_next;
  logic [31:0] r_skid_pc, w_skid_pc_next;
  logic [31:0] r_instr_id, w_instr_id_next;
  logic [31:0] r_pc_id, w_pc_id_next;
  logic        r_valid_id, w_valid_id_next;

  logic [31:0] w_redirect_target;
  logic        w_if_free;

  // Low address bits of the target are dropped so every fetch is word aligned
  assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;
  // IF/ID can take a new word when it is empty or being consumed this cycle
  assign w_if_free         = !r_valid_id || !stall_id;

  assign imem_req       = (r_state == S_REQ) && !rst;
  assign imem_addr      = r_fetch_pc;
  assign instruccion_id = r_instr_id;
  assign pc_id          = r_pc_id;
  assign valid_id       = r_valid_id;

  // Next-state and datapath update; redirect overrides everything including stall
  always_comb begin
    w_state_next       = r_state;
    w_fetch_pc_next    = r_fetch_pc;
    w_inflight_pc_next = r_inflight_pc;
    w_kill_next        = r_kill;
    w_skid_instr_next  = r_skid_instr;
    w_skid_pc_next     = r_skid_pc;
    w_instr_id_next    = r_instr_id;
    w_pc_id_next       = r_pc_id;
    w_valid_id_next    = r_valid_id;

    if (redirect) begin
      w_fetch_pc_next = w_redirect_target;
      w_valid_id_next = 1'b0;
      w_instr_id_next = NOP;
      case (r_state)
        S_REQ: begin
          // An accepted request must still be drained, so mark it dead
          if (imem_ack) begin
            w_state_next = S_WAIT;
            w_kill_next  = 1'b1;
          end else begin
            w_state_next = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            w_state_next = S_REQ;
            w_kill_next  = 1'b0;
          end else begin
            w_state_next = S_WAIT;
            w_kill_next  = 1'b1;
          end
        end
        default: begin
          // Leaving FULL empties the skid buffer
          w_state_next = S_REQ;
        end
      endcase
    end else begin
      // Decode consumed the current entry and nothing replaces it
      if (!stall_id) begin
        w_valid_id_next = 1'b0;
      end
      case (r_state)
        S_REQ: begin
          if (imem_ack) begin
            w_inflight_pc_next = r_fetch_pc;
            w_fetch_pc_next    = r_fetch_pc + 32'd4;
            w_state_next       = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (r_kill) begin
              w_kill_next  = 1'b0;
              w_state_next = S_REQ;
            end else if (w_if_free) begin
              w_instr_id_next = imem_rdata;
              w_pc_id_next    = r_inflight_pc;
              w_valid_id_next = 1'b1;
              w_state_next    = S_REQ;
            end else begin
              w_skid_instr_next = imem_rdata;
              w_skid_pc_next    = r_inflight_pc;
              w_state_next      = S_FULL;
            end
          end
        end
        S_FULL: begin
          if (!stall_id) begin
            w_instr_id_next = r_skid_instr;
            w_pc_id_next    = r_skid_pc;
            w_valid_id_next = 1'b1;
            w_state_next    = S_REQ;
          end
        end
        default: begin
          w_state_next = S_REQ;
        end
      endcase
    end
  end

  // FSM state and fetch control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_REQ;
      r_fetch_pc    <= RESET_PC_ALIGNED;
      r_inflight_pc <= 32'd0;
      r_kill        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_fetch_pc    <= w_fetch_pc_next;
      r_inflight_pc <= w_inflight_pc_next;
      r_kill        <= w_kill_next;
    end
  end

  // Skid buffer and IF/ID pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skid_instr <= 32'd0;
      r_skid_pc    <= 32'd0;
      r_instr_id   <= NOP;
      r_pc_id      <= 32'd0;
      r_valid_id   <= 1'b0;
    end else begin
      r_skid_instr <= w_skid_instr_next;
      r_skid_pc    <= w_skid_pc_next;
      r_instr_id   <= w_instr_id_next;
      r_pc_id      <= w_pc_id_next;
      r_valid_id   <= w_valid_id_next;
    end
  end

endmodule

// File: tb/tb_etapa_fetch.sv
`timescale 1ns/1ps
// Bench for etapa_fetch: a randomized instruction memory, directed scenarios, and a
// scoreboard. The scoreboard holds the expected program-order stream (pc, word),
// which restarts at every reset or redirect.
module tb_etapa_fetch;

  localparam logic [31:0] NOP_W     = 32'h0000_0013;
  localparam logic [31:0] MAIN_RPC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_RPC  = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_id;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruccion_id;
  logic [31:0] pc_id;
  logic        valid_id;

  logic        w_req, w_ack, w_rvalid, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;

  etapa_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall_id(stall_id), .redirect(redirect), .redirect_pc(redirect_pc),
    .instruccion_id(instruccion_id), .pc_id(pc_id), .valid_id(valid_id)
  );

  etapa_fetch #(.RESET_PC(WRAP_RPC)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .stall_id(1'b0), .redirect(1'b0), .redirect_pc(32'd0),
    .instruccion_id(w_instr), .pc_id(w_pc), .valid_id(w_valid)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_tx     = 0;

  int ack_pct = 100;
  int lat_min = 1;
  int lat_max = 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] path_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected stream restarts at a new program-order address
  task automatic path_start(input logic [31:0] pc);
    exp_q.delete();
    path_pc = pc & 32'hFFFF_FFFC;
    extend_path();
  endtask

  task automatic extend_path();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: path_pc, ins: mem_word(path_pc)});
      path_pc = path_pc + 32'd4;
    end
  endtask

  // Main-port instruction memory: random ack delay and response latency
  bit m_pend;
  int m_cnt;
  logic [31:0] m_addr;
  initial begin
    imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    m_pend = 1'b0; m_cnt = 0; m_addr = 32'd0;
    forever begin
      @(posedge clk); #2;
      imem_ack = 1'b0;
      imem_rvalid = 1'b0;
      if (rst) begin
        m_pend = 1'b0;
      end else begin
        if (m_pend) begin
          if (m_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(m_addr);
            m_pend      = 1'b0;
          end else begin
            m_cnt--;
          end
        end
        if (imem_req) begin
          chk("one_outstanding", {31'd0, m_pend}, 32'd0);
          if (int'($urandom_range(99)) < ack_pct) begin
            imem_ack = 1'b1;
            m_pend   = 1'b1;
            m_addr   = imem_addr;
            m_cnt    = int'($urandom_range(lat_max, lat_min)) - 1;
          end
        end
      end
    end
  end

  // Wrap-instance memory: acks at once, answers one cycle later
  bit w_pend;
  logic [31:0] w_pend_addr;
  initial begin
    w_ack = 1'b0; w_rvalid = 1'b0; w_rdata = 32'd0;
    w_pend = 1'b0; w_pend_addr = 32'd0;
    forever begin
      @(posedge clk); #2;
      w_rvalid = w_pend && !rst;
      w_rdata  = mem_word(w_pend_addr);
      w_pend   = 1'b0;
      w_ack    = w_req && !rst;
      if (w_ack) begin
        w_pend      = 1'b1;
        w_pend_addr = w_addr;
      end
    end
  end

  // Monitor: bus protocol checks and scoreboard pops on each consumed instruction
  logic prev_req, prev_ack, prev_redir, prev_rst;
  logic [31:0] prev_addr;
  initial begin
    prev_req = 1'b0; prev_ack = 1'b0; prev_redir = 1'b0; prev_rst = 1'b1; prev_addr = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("req_in_reset", {31'd0, imem_req}, 32'd0);
      end else begin
        if (imem_req) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        if (prev_req && !prev_ack && !prev_redir && !prev_rst) begin
          chk("req_held", {31'd0, imem_req}, 32'd1);
          chk("addr_held", imem_addr, prev_addr);
        end
        if (valid_id && !stall_id && !redirect) begin
          extend_path();
          mon_e = exp_q.pop_front();
          n_tx++;
          $display("tx %0d: pc_id=%h instr=%h expected pc=%h instr=%h",
                   n_tx, pc_id, instruccion_id, mon_e.pc, mon_e.ins);
          chk("sb_pc_id", pc_id, mon_e.pc);
          chk("sb_instr", instruccion_id, mon_e.ins);
        end
      end
      prev_req = imem_req; prev_ack = imem_ack; prev_redir = redirect;
      prev_rst = rst; prev_addr = imem_addr;
    end
  end

  task automatic cyc();
    @(posedge clk); #3;
  endtask

  // Holds reset for n edges, checks reset values, releases; returns at +3 of cycle 0
  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    redirect = 1'b0;
    path_start(MAIN_RPC);
    repeat (n) @(posedge clk);
    #3;
    chk("rst_valid_id", {31'd0, valid_id}, 32'd0);
    chk("rst_instr", instruccion_id, NOP_W);
    chk("rst_pc_id", pc_id, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_wrap_req", {31'd0, w_req}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
  endtask

  task automatic wait_req(input int maxc, input string name);
    int k;
    k = 0;
    while (!imem_req && k < maxc) begin cyc(); k++; end
    if (!imem_req) chk({name, "_timeout"}, {31'd0, imem_req}, 32'd1);
  endtask

  task automatic wait_valid(input int maxc, input string name);
    int k;
    k = 0;
    while (!valid_id && k < maxc) begin cyc(); k++; end
    if (!valid_id) chk({name, "_timeout"}, {31'd0, valid_id}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx0;
    logic [31:0] rp;
    rst = 1'b1; stall_id = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    path_pc = MAIN_RPC;

    // Back-to-back fetch with a 1-cycle memory; also the wrap instance
    ack_pct = 100; lat_min = 1; lat_max = 1;
    do_reset(2);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("p1_valid_c%0d", c), {31'd0, valid_id}, (c >= 2 && c % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("p1_req_c%0d", c), {31'd0, imem_req}, (c % 2 == 0) ? 32'd1 : 32'd0);
      if (c % 2 == 0) begin
        chk($sformatf("p1_addr_c%0d", c), imem_addr, 32'(2 * c));
        chk($sformatf("p1_wrap_addr_c%0d", c), w_addr, WRAP_RPC + 32'(2 * c));
      end
      if (c < 2) chk($sformatf("p1_nop_c%0d", c), instruccion_id, NOP_W);
      if (c >= 2 && c % 2 == 0) begin
        chk($sformatf("p1_pc_id_c%0d", c), pc_id, 32'(2 * c - 4));
        chk($sformatf("p1_wrap_pc_c%0d", c), w_pc, WRAP_RPC + 32'(2 * c - 4));
      end
      cyc();
    end

    // Decode stall across two responses: second goes to the skid
    stall_id = 1'b1;
    do_reset(2);
    repeat (4) cyc();
    chk("p2_full_req", {31'd0, imem_req}, 32'd0);
    chk("p2_full_valid", {31'd0, valid_id}, 32'd1);
    chk("p2_full_pc_id", pc_id, 32'd0);
    cyc();
    chk("p2_full_req2", {31'd0, imem_req}, 32'd0);
    chk("p2_hold_pc_id", pc_id, 32'd0);
    stall_id = 1'b0;
    lat_min = 3; lat_max = 3;
    cyc();
    chk("p2_skid_pc_id", pc_id, 32'd4);
    chk("p2_skid_valid", {31'd0, valid_id}, 32'd1);
    chk("p2_next_req", {31'd0, imem_req}, 32'd1);
    chk("p2_next_addr", imem_addr, 32'd8);

    // Redirect while the addr-8 request waits for its response
    stall_id = 1'b1;
    cyc();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    path_start(32'h0000_0103);
    cyc();
    redirect = 1'b0;
    stall_id = 1'b0;
    chk("p3_valid", {31'd0, valid_id}, 32'd0);
    chk("p3_nop", instruccion_id, NOP_W);
    chk("p3_req_waits", {31'd0, imem_req}, 32'd0);
    wait_req(10, "p3_req");
    chk("p3_addr", imem_addr, 32'h0000_0100);
    lat_min = 1; lat_max = 1;
    wait_valid(12, "p3_valid");
    chk("p3_pc_id", pc_id, 32'h0000_0100);
    chk("p3_instr", instruccion_id, mem_word(32'h0000_0100));
    cyc();

    // Redirect in the same cycle as the ack
    wait_req(10, "p4_req");
    redirect = 1'b1;
    redirect_pc = 32'h0000_0202;
    path_start(32'h0000_0202);
    cyc();
    redirect = 1'b0;
    chk("p4_killed_wait", {31'd0, imem_req}, 32'd0);
    wait_req(10, "p4_req2");
    chk("p4_addr", imem_addr, 32'h0000_0200);
    repeat (6) cyc();

    // Reset while stalled with the skid full
    stall_id = 1'b1;
    do_reset(2);
    repeat (4) cyc();
    chk("p5_full_req", {31'd0, imem_req}, 32'd0);
    chk("p5_full_valid", {31'd0, valid_id}, 32'd1);
    do_reset(1);
    chk("p5_restart_req", {31'd0, imem_req}, 32'd1);
    chk("p5_restart_addr", imem_addr, MAIN_RPC);
    chk("p5_restart_valid", {31'd0, valid_id}, 32'd0);
    stall_id = 1'b0;

    // Randomized traffic: stalls, redirects, occasional resets
    tx0 = n_tx;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (i % 500 == 0) begin
        if ((i / 500) % 2 == 0) begin ack_pct = 50; lat_min = 1; lat_max = 3; end
        else begin ack_pct = 100; lat_min = 1; lat_max = 1; end
      end
      stall_id = ($urandom_range(3) == 0);
      if ($urandom_range(699) == 0) begin
        do_reset(1);
      end else begin
        redirect = ($urandom_range(19) == 0);
        if (redirect) begin
          rp = $urandom();
          if ($urandom_range(3) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'h0000_000F);
          redirect_pc = rp;
          path_start(rp);
        end
      end
    end
    stall_id = 1'b0;
    redirect = 1'b0;
    repeat (10) cyc();
    chk("random_progress", {31'd0, (n_tx - tx0) > 50}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
